// File: rtl/mul_iter_seq_nbpc.sv
// mul_iter_seq_nbpc: iterative multiplier retiring BPC multiplier bits per clock into a 2*WIDTH-bit product
//   clk, rst_n (async active-low)
//   in_valid/in_ready, a, b, is_signed : operand handshake, accepted only in IDLE
//   out_valid/out_ready, product       : result handshake, product held while out_valid
//   busy                               : high in RUN or DONE
//   MUL_EARLY_TERM_EN                  : when defined, leave RUN once the remaining multiplier bits are zero
module mul_iter_seq_nbpc #(
  parameter int WIDTH = 32,
  parameter int BPC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int N = WIDTH / BPC;
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mcand, mplier;
  logic neg, last, early, fin;
  logic [CW-1:0] cnt;
  logic [PW-1:0] acc, term, acc_nx;
  // magnitudes are unsigned WIDTH-bit values, so the most-negative operand cannot overflow
  always_comb begin
    term = PW'(mcand) * PW'(mplier[BPC-1:0]);
    acc_nx = acc + (term << (BPC * cnt));
    last = cnt == CW'(N - 1);
  end
`ifdef MUL_EARLY_TERM_EN
  assign early = mplier == '0;
`else
  assign early = 1'b0;
`endif
  assign fin = last | early;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? RUN : IDLE;
      RUN: state_nx = fin ? DONE : RUN;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand <= '0;
      mplier <= '0;
      neg <= 1'b0;
      cnt <= '0;
      acc <= '0;
      product <= '0;
    end else if (state == IDLE && in_valid) begin
      mcand <= (is_signed && a[WIDTH-1]) ? -a : a;
      mplier <= (is_signed && b[WIDTH-1]) ? -b : b;
      neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      cnt <= '0;
      acc <= '0;
    end else if (state == RUN) begin
      acc <= acc_nx;
      mplier <= mplier >> BPC;
      cnt <= cnt + 1'b1;
      if (fin) product <= neg ? -acc_nx : acc_nx;
    end
endmodule

// File: tb/tb_mul_iter_seq_nbpc.sv
// tb_mul_iter_seq_nbpc: directed self-checking bench with a cycle-level reference model
module tb_mul_iter_seq_nbpc;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, is_signed = 1'b0;
  logic out_valid, out_ready = 1'b0, busy;
  logic [31:0] a = '0, b = '0;
  logic [63:0] product;
  int vectors = 0, miscompares = 0;
  logic chk_en = 1'b0;
  mul_iter_seq_nbpc #(.WIDTH(32), .BPC(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .is_signed(is_signed), .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return s ? 64'(sx * sy) : {32'b0, x} * {32'b0, y};
  endfunction
  function automatic int lat(input logic [31:0] y, input logic s);
`ifdef MUL_EARLY_TERM_EN
    logic [31:0] m;
    int d;
    m = (s && y[31]) ? -y : y;
    d = 0;
    while (m != 0) begin
      m = m >> 2;
      d++;
    end
    return (d >= 16) ? 16 : d + 1;
`else
    return 16;
`endif
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: countdown to result, then a held product until out_ready
  int m_left = 0;
  logic m_valid = 1'b0;
  logic [63:0] m_prod = '0, m_exp = '0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_left <= 0;
      m_valid <= 1'b0;
      m_prod <= '0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_left > 0) begin
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_prod <= m_exp;
      end
      m_left <= m_left - 1;
    end else if (in_valid) begin
      m_left <= lat(b, is_signed);
      m_exp <= ref_mul(a, b, is_signed);
    end
  always @(negedge clk)
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(!(m_valid || m_left > 0)));
      chk("busy", 64'(busy), 64'(m_valid || m_left > 0));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("product", product, m_prod);
    end
  task automatic op(input logic [31:0] ta, input logic [31:0] tb, input logic ts, input logic [63:0] lit, input int hold);
    int cyc;
    chk("model_pin", ref_mul(ta, tb, ts), lit);
    chk("ready_before_op", 64'(in_ready), 64'd1);
    a = ta;
    b = tb;
    is_signed = ts;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    is_signed = ~ts;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(lat(tb, ts)));
    chk("result", product, lit);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      chk("hold_product", product, lit);
      chk("hold_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    chk("ready_after", 64'(in_ready), 64'd1);
    chk("valid_after", 64'(out_valid), 64'd0);
  endtask
  initial begin
`ifndef MUL_EARLY_TERM_EN
    chk("lat_pin", 64'(lat(32'd9, 1'b0)), 64'd16);
`else
    chk("lat_pin", 64'(lat(32'd9, 1'b0)), 64'd3);
`endif
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    chk("reset_product", product, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    op(32'd3, 32'd5, 1'b0, 64'h000000000000000F, 0);
    op(32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFFFFFFFFF1, 0);
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 0);
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, 0);
    op(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 0);
    op(32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000, 0);
    op(32'h80000000, 32'd2, 1'b1, 64'hFFFFFFFF00000000, 0);
    op(32'hFFFFFFFB, 32'd0, 1'b1, 64'h0000000000000000, 0);
    op(32'd12345, 32'hFFFFFFFE, 1'b1, 64'hFFFFFFFFFFFF9F8E, 5);
    a = 32'd1000;
    b = 32'hDEADBEEF;
    is_signed = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", product, 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    op(32'd7, 32'd9, 1'b0, 64'd63, 0);
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
